// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver (serial line -> parallel word).
// Two-flop input synchroniser, false-start rejection, framing/parity error
// flags and a single-cycle o_dv strobe.
// Optional build macro: UART_RX_MAJORITY_EN -- each bit decision becomes a
// 2-of-3 vote of rx_s at cnt == T-2, T-1, T instead of a single sample at T.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | line idle, waiting for rx_s low
// S_START  | half a bit into the start bit; a high sample there is a glitch
// S_DATA   | shifting in DATA_BITS data bits, LSB first
// S_PARITY | checking the parity bit (only reached when PARITY != 0)
// S_STOP   | sampling STOP_BITS stop bits, any low one is a framing error
// S_DONE   | one cycle: publish word and flags, strobe o_dv next cycle
module uart_rx_cfg #(
    parameter int CLK_PER_BIT = 10417,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_serial_data,
    output logic [DATA_BITS-1:0] o_rx_byte,
    output logic                 o_dv,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] HALF_T = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_T  = CW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frm_q, frm_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] rx_byte_q;
    logic                 dv_q, frame_err_q, parity_err_q;
    logic [CW-1:0]        sample_t;
    logic                 at_t;
    logic                 bit_val;

    // Start bit is sampled at its middle, every later bit one full period on.
    assign sample_t = (state_q == S_START) ? HALF_T : BIT_T;
    assign at_t     = (cnt_q == sample_t);

`ifdef UART_RX_MAJORITY_EN
    logic vote0_q, vote1_q;

    // Capture the two early votes ahead of each nominal sample point.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vote0_q <= 1'b1;
            vote1_q <= 1'b1;
        end else begin
            if (cnt_q == sample_t - CW'(2)) vote0_q <= rx_s_q;
            if (cnt_q == sample_t - CW'(1)) vote1_q <= rx_s_q;
        end
    end

    assign bit_val = (vote0_q & vote1_q) | (vote0_q & rx_s_q) | (vote1_q & rx_s_q);
`else
    assign bit_val = rx_s_q;
`endif

    // Synchroniser, FSM state, counters and per-frame working registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            frm_q     <= 1'b0;
            par_q     <= 1'b0;
        end else begin
            rx_meta_q <= i_serial_data;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            frm_q     <= frm_d;
            par_q     <= par_d;
        end
    end

    // Next-state logic, bit sampling and per-frame error accumulation.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        frm_d     = frm_q;
        par_d     = par_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    frm_d   = 1'b0;
                    par_d   = 1'b0;
                end
            end
            S_START: begin
                if (at_t) begin
                    if (!bit_val) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (at_t) begin
                    shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_PARITY: begin
                if (at_t) begin
                    // Odd parity wants XOR(data, p) == 1, even wants 0.
                    par_d     = (PARITY == 1) ? ~((^shift_q) ^ bit_val) : ((^shift_q) ^ bit_val);
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                end
            end
            S_STOP: begin
                if (at_t) begin
                    if (!bit_val) frm_d = 1'b1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q == S_IDLE || state_d != state_q || at_t) cnt_d = '0;
        else                                                  cnt_d = cnt_q + CW'(1);
    end

    // Output registers: published only in DONE, held until the next DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_byte_q    <= '0;
            dv_q         <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            dv_q <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                rx_byte_q    <= shift_q;
                frame_err_q  <= frm_q;
                parity_err_q <= par_q;
            end
        end
    end

    assign o_rx_byte    = rx_byte_q;
    assign o_dv         = dv_q;
    assign o_frame_err  = frame_err_q;
    assign o_parity_err = parity_err_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four instances with different framing
// parameters, each with its own serial line and reset.
module tb_uart_rx_cfg;

    localparam int C = 16;
    localparam int H = C / 2;

    logic       clk = 1'b0;
    logic [3:0] rst_n;
    logic [3:0] ser;
    logic [7:0] byte0, byte1, byte2;
    logic [8:0] byte3;
    logic [3:0] dv, fe, pe, busy;

    int cyc = 0;
    int dv_cnt[4] = '{default: 0};
    int dv_cyc[4] = '{default: 0};
    int n_cmp = 0;
    int n_bad = 0;
    int m;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (dv[i]) begin
                dv_cnt[i]++;
                dv_cyc[i] = cyc;
            end
        end
    end

    // u0: 8N1   u1: 8E1   u2: 8N2   u3: 9O1
    uart_rx_cfg #(.CLK_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_serial_data(ser[0]), .o_rx_byte(byte0),
        .o_dv(dv[0]), .o_frame_err(fe[0]), .o_parity_err(pe[0]), .o_busy(busy[0]));
    uart_rx_cfg #(.CLK_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_serial_data(ser[1]), .o_rx_byte(byte1),
        .o_dv(dv[1]), .o_frame_err(fe[1]), .o_parity_err(pe[1]), .o_busy(busy[1]));
    uart_rx_cfg #(.CLK_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n[2]), .i_serial_data(ser[2]), .o_rx_byte(byte2),
        .o_dv(dv[2]), .o_frame_err(fe[2]), .o_parity_err(pe[2]), .o_busy(busy[2]));
    uart_rx_cfg #(.CLK_PER_BIT(C), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u3 (
        .i_clk(clk), .i_rst_n(rst_n[3]), .i_serial_data(ser[3]), .o_rx_byte(byte3),
        .o_dv(dv[3]), .o_frame_err(fe[3]), .o_parity_err(pe[3]), .o_busy(busy[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive n bit periods LSB first; gl[k] inverts bit k for the one cycle
    // that lands on the receiver's nominal sample point.
    task automatic send_bits(input int idx, input logic [15:0] bits, input int n, input logic [15:0] gl);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < C; j++) begin
                ser[idx] = bits[k] ^ (gl[k] && (j == H));
                @(negedge clk);
            end
        end
        ser[idx] = 1'b1;
    endtask

    function automatic logic [15:0] mk(input logic [8:0] d, input int nd, input bit has_p,
                                       input bit p, input logic [1:0] st);
        logic [15:0] b;
        int k;
        b = '1;
        b[0] = 1'b0;
        k = 1;
        for (int i = 0; i < nd; i++) begin
            b[k] = d[i];
            k++;
        end
        if (has_p) begin
            b[k] = p;
            k++;
        end
        b[k]     = st[0];
        b[k + 1] = st[1];
        return b;
    endfunction

    initial begin
        rst_n = 4'b0000;
        ser   = 4'b1111;
        idle(3);
        chk("reset_u0", {23'd0, byte0, dv[0], fe[0], pe[0], busy[0]}, 32'd0);
        chk("reset_u1", {23'd0, byte1, dv[1], fe[1], pe[1], busy[1]}, 32'd0);
        chk("reset_u2", {23'd0, byte2, dv[2], fe[2], pe[2], busy[2]}, 32'd0);
        chk("reset_u3", {22'd0, byte3, dv[3], fe[3], pe[3], busy[3]}, 32'd0);
        rst_n = 4'b1111;
        idle(5);

        // 8N1 frame 0xA5 with exact latency
        m = cyc;
        send_bits(0, mk(9'h0A5, 8, 0, 0, 2'b11), 10, 16'h0);
        idle(2 * C);
        chk("t1_dv_count", dv_cnt[0], 1);
        chk("t1_byte", byte0, 8'hA5);
        chk("t1_flags", {fe[0], pe[0]}, 2'b00);
        chk("t1_latency", dv_cyc[0], m + 1 + 3 + H + 9 * C);
        chk("t1_busy_idle", busy[0], 1'b0);

        // 8E1: 0x3C has even weight so correct parity is 0
        send_bits(1, mk(9'h03C, 8, 1, 1, 2'b11), 11, 16'h0);
        idle(2 * C);
        chk("t2_dv_count", dv_cnt[1], 1);
        chk("t2_byte", byte1, 8'h3C);
        chk("t2_par_err", pe[1], 1'b1);
        chk("t2_frm_err", fe[1], 1'b0);
        send_bits(1, mk(9'h03C, 8, 1, 0, 2'b11), 11, 16'h0);
        idle(2 * C);
        chk("t2b_dv_count", dv_cnt[1], 2);
        chk("t2b_par_err", pe[1], 1'b0);
        chk("t2b_byte", byte1, 8'h3C);

        // 8N2 with second stop bit low
        send_bits(2, mk(9'h081, 8, 0, 0, 2'b01), 11, 16'h0);
        idle(2 * C);
        chk("t3_dv_count", dv_cnt[2], 1);
        chk("t3_byte", byte2, 8'h81);
        chk("t3_frm_err", fe[2], 1'b1);
        chk("t3_par_err", pe[2], 1'b0);

        // 4-cycle low glitch on idle line: START aborts, flags held
        repeat (4) begin
            ser[2] = 1'b0;
            @(negedge clk);
        end
        chk("t4_busy_in_start", busy[2], 1'b1);
        ser[2] = 1'b1;
        idle(2 * C);
        chk("t4_busy_dropped", busy[2], 1'b0);
        chk("t4_no_dv", dv_cnt[2], 1);
        chk("t4_frm_held", fe[2], 1'b1);
        chk("t4_byte_held", byte2, 8'h81);

        // Reset during data bit 3 of 0x55, then a clean 0xF0
        send_bits(0, mk(9'h055, 8, 0, 0, 2'b11), 4, 16'h0);
        ser[0] = 1'b0;
        idle(H);
        rst_n[0] = 1'b0;
        ser[0]   = 1'b1;
        idle(3);
        chk("t5_in_reset", {23'd0, byte0, dv[0], fe[0], pe[0], busy[0]}, 32'd0);
        rst_n[0] = 1'b1;
        idle(2 * C);
        chk("t5_no_dv_abort", dv_cnt[0], 1);
        send_bits(0, mk(9'h0F0, 8, 0, 0, 2'b11), 10, 16'h0);
        idle(2 * C);
        chk("t5_dv_count", dv_cnt[0], 2);
        chk("t5_byte", byte0, 8'hF0);
        chk("t5_flags", {fe[0], pe[0]}, 2'b00);

        // 9O1: 0x1AB has six ones, so odd parity bit is 1
        m = cyc;
`ifdef UART_RX_MAJORITY_EN
        send_bits(3, mk(9'h1AB, 9, 1, 1, 2'b11), 12, 16'b0000_0011_1111_1110);
`else
        send_bits(3, mk(9'h1AB, 9, 1, 1, 2'b11), 12, 16'h0);
`endif
        idle(2 * C);
        chk("t6_dv_count", dv_cnt[3], 1);
        chk("t6_byte", byte3, 9'h1AB);
        chk("t6_flags", {fe[3], pe[3]}, 2'b00);
        chk("t6_latency", dv_cyc[3], m + 1 + 3 + H + 11 * C);
        send_bits(3, mk(9'h1AB, 9, 1, 0, 2'b11), 12, 16'h0);
        idle(2 * C);
        chk("t6b_dv_count", dv_cnt[3], 2);
        chk("t6b_par_err", pe[3], 1'b1);
        chk("t6b_byte", byte3, 9'h1AB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
